play_period: RTL and testbench

- Gameplay-timing stage that sits directly upstream of the post-period stage.
- A one-cycle playSig starts a timed guessing window. The block counts player button presses, drives the 4-digit display with seconds remaining and the current count, and fires the one-cycle postSig that hands control to the post-period stage.
- At hand-off it latches whether the final count matched the level's target symbol count.

---
 rtl/symcounter_pkg.sv | 60 ++++++
 rtl/seg_decoder.sv | 37 +++
 rtl/play_period.sv | 178 +++++++++++++++++
 tb/tb_play_period.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/symcounter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : symcounter_pkg
//  Description : Shared definitions for the symbol-counter game stages:
//                FSM state encoding, seven-segment patterns and the
//                binary to two-digit decimal split helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package symcounter_pkg;

    // Game-stage state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Active-low segment patterns, bit order {dp,g,f,e,d,c,b,a}
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;

    // Split a value 0..99 into {tens, units}. Units are formed in 4-bit
    // arithmetic: value - 10*tens fits in a nibble, so only the low nibble
    // of 10*tens (the offset below) is needed.
    function automatic logic [7:0] splitDecimal(input logic [6:0] value);
        logic [3:0] tens;
        logic [3:0] offs;
        if (value >= 7'd90) begin
            tens = 4'd9; offs = 4'd10;
        end else if (value >= 7'd80) begin
            tens = 4'd8; offs = 4'd0;
        end else if (value >= 7'd70) begin
            tens = 4'd7; offs = 4'd6;
        end else if (value >= 7'd60) begin
            tens = 4'd6; offs = 4'd12;
        end else if (value >= 7'd50) begin
            tens = 4'd5; offs = 4'd2;
        end else if (value >= 7'd40) begin
            tens = 4'd4; offs = 4'd8;
        end else if (value >= 7'd30) begin
            tens = 4'd3; offs = 4'd14;
        end else if (value >= 7'd20) begin
            tens = 4'd2; offs = 4'd4;
        end else if (value >= 7'd10) begin
            tens = 4'd1; offs = 4'd10;
        end else begin
            tens = 4'd0; offs = 4'd0;
        end
        return {tens, value[3:0] - offs};
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg_decoder
//  Description : One decimal digit plus blank request to an active-low
//                seven-segment pattern. Codes 10..15 display blank.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_decoder
    import symcounter_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    output logic [7:0] o_seg
);

    // Pattern lookup with blank override
    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank) begin
            case (i_digit)
                4'd0:    o_seg = SEG_0;
                4'd1:    o_seg = SEG_1;
                4'd2:    o_seg = SEG_2;
                4'd3:    o_seg = SEG_3;
                4'd4:    o_seg = SEG_4;
                4'd5:    o_seg = SEG_5;
                4'd6:    o_seg = SEG_6;
                4'd7:    o_seg = SEG_7;
                4'd8:    o_seg = SEG_8;
                4'd9:    o_seg = SEG_9;
                default: o_seg = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/play_period.sv
`default_nettype none
// ============================================================================
//  Module      : play_period
//  Description : Timed guessing window. Counts player presses while a
//                seconds countdown runs, drives the 4-digit display and
//                hands off to the post-period stage with a one-cycle
//                postSig and a latched guess-correct flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module play_period
    import symcounter_pkg::*;
#(
    parameter int PLAY_SECONDS = 10,
    parameter int MAX_GUESS    = 99
) (
    input  logic       Clk100M,
    input  logic       Reset,
    input  logic       Clk1Hz,
    input  logic       playSig,
    input  logic       btnPulse,
    input  logic [7:0] targetCount,
    output logic       postSig,
    output logic       playing,
    output logic [7:0] guessCount,
    output logic       guessCorrect,
    output logic [7:0] playSeg0,
    output logic [7:0] playSeg1,
    output logic [7:0] playSeg2,
    output logic [7:0] playSeg3
);

    localparam logic [6:0] c_playSeconds = 7'(PLAY_SECONDS);
    localparam logic [6:0] c_maxGuess    = 7'(MAX_GUESS);

    logic [1:0] r_state;
    logic [1:0] w_nextState;
    logic       w_playingNext;
    logic       w_postNext;

    logic       r_playing;
    logic       r_postSig;
    logic [6:0] r_secondsLeft;
    logic [6:0] r_guessCount;
    logic [6:0] w_countNext;
    logic       r_guessCorrect;
    logic [7:0] r_targetReg;

    logic [7:0] w_secSplit;
    logic [7:0] w_cntSplit;
    logic       w_idle;
    logic [3:0] w_digit [4];
    logic       w_blank [4];
    logic [7:0] w_seg   [4];
    logic [7:0] r_seg   [4];

    // State register
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: the window closes on the tick that empties the countdown
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: if (playSig) w_nextState = ST_PLAY;
            ST_PLAY: if (Clk1Hz && (r_secondsLeft <= 7'd1)) w_nextState = ST_DONE;
            ST_DONE: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Output decode of the upcoming state, registered below so outputs are glitch-free
    always_comb begin
        w_playingNext = (w_nextState == ST_PLAY);
        w_postNext    = (w_nextState == ST_DONE);
    end

    // Registered playing / postSig outputs
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            r_playing <= 1'b0;
            r_postSig <= 1'b0;
        end else begin
            r_playing <= w_playingNext;
            r_postSig <= w_postNext;
        end
    end

    // Saturating press count, only advanced while the window is open
    always_comb begin
        w_countNext = r_guessCount;
        if ((r_state == ST_PLAY) && btnPulse && (r_guessCount < c_maxGuess)) begin
            w_countNext = r_guessCount + 7'd1;
        end
    end

    // Countdown, press counter, target capture and result latch
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            r_secondsLeft  <= 7'd0;
            r_guessCount   <= 7'd0;
            r_guessCorrect <= 1'b0;
            r_targetReg    <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (playSig) begin
                        r_secondsLeft  <= c_playSeconds;
                        r_guessCount   <= 7'd0;
                        r_guessCorrect <= 1'b0;
                        r_targetReg    <= targetCount;
                    end
                end
                ST_PLAY: begin
                    r_guessCount <= w_countNext;
                    if (Clk1Hz && (r_secondsLeft != 7'd0)) begin
                        r_secondsLeft <= r_secondsLeft - 7'd1;
                    end
                    // Compare against the count including a press in the final-tick cycle
                    if (w_nextState == ST_DONE) begin
                        r_guessCorrect <= ({1'b0, w_countNext} == r_targetReg);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Digit selection: seconds on the left pair, count on the right pair
    always_comb begin
        w_secSplit = splitDecimal(r_secondsLeft);
        w_cntSplit = splitDecimal(r_guessCount);
        w_idle     = (r_state == ST_IDLE);
        w_digit[3] = w_secSplit[7:4];
        w_digit[2] = w_secSplit[3:0];
        w_digit[1] = w_cntSplit[7:4];
        w_digit[0] = w_cntSplit[3:0];
        w_blank[3] = w_idle || (w_secSplit[7:4] == 4'd0);
        w_blank[2] = w_idle;
        w_blank[1] = w_idle || (w_cntSplit[7:4] == 4'd0);
        w_blank[0] = w_idle;
    end

    generate
        for (genvar i = 0; i < 4; i++) begin : g_digit
            seg_decoder u_dec (
                .i_digit (w_digit[i]),
                .i_blank (w_blank[i]),
                .o_seg   (w_seg[i])
            );
        end
    endgenerate

    // Display register; IDLE blanks everything so the post stage owns the display
    always_ff @(posedge Clk100M or posedge Reset) begin
        if (Reset) begin
            for (int k = 0; k < 4; k++) r_seg[k] <= SEG_BLANK;
        end else begin
            for (int k = 0; k < 4; k++) r_seg[k] <= w_seg[k];
        end
    end

    assign postSig      = r_postSig;
    assign playing      = r_playing;
    assign guessCount   = {1'b0, r_guessCount};
    assign guessCorrect = r_guessCorrect;
    assign playSeg0     = r_seg[0];
    assign playSeg1     = r_seg[1];
    assign playSeg2     = r_seg[2];
    assign playSeg3     = r_seg[3];

endmodule
`default_nettype wire

// File: tb/tb_play_period.sv
`default_nettype none
// ============================================================================
//  Module      : tb_play_period
//  Description : Directed self-checking bench for play_period with a
//                3-second window and a tick every 100 clock cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_play_period;

    localparam logic [7:0] S_BL = 8'hFF;
    localparam logic [7:0] S_0  = 8'hC0;
    localparam logic [7:0] S_1  = 8'hF9;
    localparam logic [7:0] S_2  = 8'hA4;
    localparam logic [7:0] S_3  = 8'hB0;
    localparam logic [7:0] S_5  = 8'h92;
    localparam logic [7:0] S_7  = 8'hF8;
    localparam logic [7:0] S_9  = 8'h90;

    logic       Clk100M = 1'b0;
    logic       Reset;
    logic       Clk1Hz;
    logic       playSig;
    logic       btnPulse;
    logic [7:0] targetCount;
    logic       postSig;
    logic       playing;
    logic [7:0] guessCount;
    logic       guessCorrect;
    logic [7:0] playSeg0, playSeg1, playSeg2, playSeg3;

    int nChecks   = 0;
    int nErrors   = 0;
    int postCount = 0;
    int p0;

    play_period #(
        .PLAY_SECONDS (3),
        .MAX_GUESS    (99)
    ) dut (
        .Clk100M      (Clk100M),
        .Reset        (Reset),
        .Clk1Hz       (Clk1Hz),
        .playSig      (playSig),
        .btnPulse     (btnPulse),
        .targetCount  (targetCount),
        .postSig      (postSig),
        .playing      (playing),
        .guessCount   (guessCount),
        .guessCorrect (guessCorrect),
        .playSeg0     (playSeg0),
        .playSeg1     (playSeg1),
        .playSeg2     (playSeg2),
        .playSeg3     (playSeg3)
    );

    always #5 Clk100M = ~Clk100M;

    // Count every postSig cycle seen
    always @(negedge Clk100M) begin
        if (postSig) postCount <= postCount + 1;
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkSegs(input string tag, input logic [7:0] s3, input logic [7:0] s2,
                             input logic [7:0] s1, input logic [7:0] s0);
        checkValue({tag, "_seg3"}, {24'd0, playSeg3}, {24'd0, s3});
        checkValue({tag, "_seg2"}, {24'd0, playSeg2}, {24'd0, s2});
        checkValue({tag, "_seg1"}, {24'd0, playSeg1}, {24'd0, s1});
        checkValue({tag, "_seg0"}, {24'd0, playSeg0}, {24'd0, s0});
    endtask

    // One clock: drive inputs, take the edge, sample 1 ns later
    task automatic stepCycle(input logic tick, input logic btn, input logic play);
        Clk1Hz   = tick;
        btnPulse = btn;
        playSig  = play;
        @(posedge Clk100M);
        #1;
        Clk1Hz   = 1'b0;
        btnPulse = 1'b0;
        playSig  = 1'b0;
    endtask

    // Window cycles fromT..toT (t=0 is the playSig cycle): tick every 100,
    // press on even t up to pressUntil, plus one extra press at extraPress
    task automatic runWindow(input int fromT, input int toT, input int pressUntil, input int extraPress);
        for (int t = fromT; t <= toT; t++) begin
            stepCycle((t % 100) == 0, (((t % 2) == 0) && (t <= pressUntil)) || (t == extraPress), 1'b0);
        end
    endtask

    task automatic startRound(input string tag, input logic [7:0] target);
        targetCount = target;
        stepCycle(1'b0, 1'b0, 1'b1);
        checkValue({tag, "_playing"}, {31'd0, playing}, 32'd1);
        checkValue({tag, "_count0"}, {24'd0, guessCount}, 32'd0);
        checkValue({tag, "_correct0"}, {31'd0, guessCorrect}, 32'd0);
    endtask

    initial begin
        Reset       = 1'b1;
        Clk1Hz      = 1'b0;
        playSig     = 1'b0;
        btnPulse    = 1'b0;
        targetCount = 8'd0;
        repeat (3) @(posedge Clk100M);
        #1;
        checkValue("rst_playing", {31'd0, playing}, 32'd0);
        checkValue("rst_post", {31'd0, postSig}, 32'd0);
        checkValue("rst_count", {24'd0, guessCount}, 32'd0);
        checkValue("rst_correct", {31'd0, guessCorrect}, 32'd0);
        checkSegs("rst", S_BL, S_BL, S_BL, S_BL);
        Reset = 1'b0;
        stepCycle(1'b0, 1'b0, 1'b0);
        stepCycle(1'b0, 1'b0, 1'b0);

        // Normal run: 5 presses, target 5
        p0 = postCount;
        startRound("r1", 8'd5);
        runWindow(1, 20, 10, 0);
        checkSegs("r1_mid", S_BL, S_3, S_BL, S_5);
        runWindow(21, 299, 10, 0);
        checkValue("r1_post_early", {31'd0, postSig}, 32'd0);
        checkValue("r1_playing_late", {31'd0, playing}, 32'd1);
        runWindow(300, 300, 10, 0);
        checkValue("r1_post", {31'd0, postSig}, 32'd1);
        checkValue("r1_playing_done", {31'd0, playing}, 32'd0);
        checkValue("r1_count", {24'd0, guessCount}, 32'd5);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkValue("r1_post_after", {31'd0, postSig}, 32'd0);
        checkValue("r1_correct", {31'd0, guessCorrect}, 32'd1);
        checkSegs("r1_done_disp", S_BL, S_0, S_BL, S_5);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkSegs("r1_idle_disp", S_BL, S_BL, S_BL, S_BL);
        checkValue("r1_post_pulses", postCount - p0, 32'd1);
        checkValue("r1_count_hold", {24'd0, guessCount}, 32'd5);

        // Mismatch: 4 presses, target 5
        startRound("r2", 8'd5);
        runWindow(1, 300, 8, 0);
        checkValue("r2_post", {31'd0, postSig}, 32'd1);
        checkValue("r2_count", {24'd0, guessCount}, 32'd4);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkValue("r2_correct", {31'd0, guessCorrect}, 32'd0);

        // Display 3/7, restart ignored, press on the final tick counted
        startRound("r3", 8'd8);
        runWindow(1, 20, 14, 0);
        checkSegs("r3_disp37", S_BL, S_3, S_BL, S_7);
        checkValue("r3_count7", {24'd0, guessCount}, 32'd7);
        stepCycle(1'b0, 1'b0, 1'b1);
        runWindow(22, 22, 0, 0);
        checkValue("r3_norestart_count", {24'd0, guessCount}, 32'd7);
        checkValue("r3_norestart_playing", {31'd0, playing}, 32'd1);
        checkSegs("r3_norestart_disp", S_BL, S_3, S_BL, S_7);
        runWindow(23, 299, 0, 0);
        checkValue("r3_post_early", {31'd0, postSig}, 32'd0);
        runWindow(300, 300, 0, 300);
        checkValue("r3_post", {31'd0, postSig}, 32'd1);
        checkValue("r3_final_press", {24'd0, guessCount}, 32'd8);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkValue("r3_correct", {31'd0, guessCorrect}, 32'd1);

        // Press and tick in the same mid-window cycle
        startRound("r4", 8'd0);
        runWindow(1, 99, 100, 0);
        checkValue("r4_count49", {24'd0, guessCount}, 32'd49);
        runWindow(100, 100, 100, 0);
        checkValue("r4_count50", {24'd0, guessCount}, 32'd50);
        runWindow(101, 101, 100, 0);
        checkSegs("r4_coinc_disp", S_BL, S_2, S_5, S_0);
        runWindow(102, 300, 100, 0);
        checkValue("r4_post", {31'd0, postSig}, 32'd1);
        checkValue("r4_count_final", {24'd0, guessCount}, 32'd50);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkValue("r4_correct", {31'd0, guessCorrect}, 32'd0);

        // Saturation: 120 presses clamp at 99
        startRound("r5", 8'd99);
        runWindow(1, 300, 240, 0);
        checkValue("r5_post", {31'd0, postSig}, 32'd1);
        checkValue("r5_count_sat", {24'd0, guessCount}, 32'd99);
        checkSegs("r5_sat_disp", S_BL, S_1, S_9, S_9);
        stepCycle(1'b0, 1'b0, 1'b0);
        checkValue("r5_correct", {31'd0, guessCorrect}, 32'd1);

        // Reset in the middle of a window
        p0 = postCount;
        startRound("r6", 8'd3);
        runWindow(1, 150, 20, 0);
        checkValue("r6_count_pre", {24'd0, guessCount}, 32'd10);
        Reset = 1'b1;
        #1;
        checkValue("r6_rst_playing", {31'd0, playing}, 32'd0);
        checkValue("r6_rst_post", {31'd0, postSig}, 32'd0);
        @(posedge Clk100M);
        #1;
        checkSegs("r6_rst_disp", S_BL, S_BL, S_BL, S_BL);
        checkValue("r6_rst_count", {24'd0, guessCount}, 32'd0);
        Reset = 1'b0;
        runWindow(151, 400, 0, 0);
        checkValue("r6_no_post", postCount - p0, 32'd0);
        checkValue("r6_idle_playing", {31'd0, playing}, 32'd0);
        checkSegs("r6_idle_disp", S_BL, S_BL, S_BL, S_BL);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
